// File: rtl/udp_receive_pkg.sv
// Shared types and constants for the UDP receive path.
//   state_type      : fragment dispatcher FSM states
//   IPV4_MF_BIT     : "more fragments" bit position inside the 16-bit flags word
//   IPV4_OFFSET_MSB : top bit of the 13-bit fragment offset (8-byte units)
//   ptr_width()     : index width for a count of entries, never below 1
package udp_receive_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_SEARCH_EMPTY,
        S_SEARCH_MATCH,
        S_FLUSH,
        S_PUSH,
        S_DRAIN,
        S_DONE
    } state_type;

    localparam int IPV4_MF_BIT     = 13;
    localparam int IPV4_OFFSET_MSB = 12;

    // $clog2 returns 0 for a count of 1, which would give a zero-width vector.
    function automatic int ptr_width(input int count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

endpackage

// File: rtl/udp_fragment_dispatcher_timer.sv
// cycle_timer: idle-cycle watchdog.
//   clock, reset_n : clock, async active-low reset
//   load           : (re)start the count at CYCLES
//   run            : timer is armed; when low the count is parked at 0
//   expired        : CYCLES consecutive running cycles have passed since the last load
module cycle_timer #(
    parameter int CYCLES = 4,
    parameter int WIDTH  = $clog2(CYCLES + 1)
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= WIDTH'(CYCLES);
        end else if (!run) begin
            count <= '0;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    // Loaded value counts as the first idle cycle, so expiry lands on the
    // CYCLES-th idle cycle.
    assign expired = run && (count <= WIDTH'(1));

endmodule

// File: rtl/udp_fragment_dispatcher.sv
// udp_fragment_dispatcher: round-robin scan of RX_QUEUES IPv4 receive queues,
// binds each datagram to one of FRAG_SLOTS reassembly slots and streams its
// payload (DATA_BYTES per beat) into that slot.
//   enable / data / data_keep / data_enable      : per-queue datagram and beats
//   ipv4_identification / ipv4_flags             : per-queue header fields
//   fragment_slot_empty / _packet_id / _next_offset : slot status
//   data_ready      : combinational, one-hot beat accept toward queue rq
//   push_data/keep  : registered beat, push_data_valid one-hot slot select
//   push_data_last  : pulse when the final fragment of a datagram completes
//   slot_claim      : pulse when an empty slot is taken
//   packet_id       : ID of datagram in flight
//   drop_pulse / drop_count : drop event and saturating total
module udp_fragment_dispatcher
    import udp_receive_pkg::*;
#(
    parameter int DATA_BYTES     = 1,
    parameter int RX_QUEUES      = 4,
    parameter int FRAG_SLOTS     = 4,
    parameter int FLUSH_BEATS    = 14,
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [RX_QUEUES-1:0]                   enable,
    input  logic [RX_QUEUES-1:0][8*DATA_BYTES-1:0] data,
    input  logic [RX_QUEUES-1:0][DATA_BYTES-1:0]   data_keep,
    input  logic [RX_QUEUES-1:0]                   data_enable,
    input  logic [RX_QUEUES-1:0][15:0]             ipv4_identification,
    input  logic [RX_QUEUES-1:0][15:0]             ipv4_flags,
    input  logic [FRAG_SLOTS-1:0]                  fragment_slot_empty,
    input  logic [FRAG_SLOTS-1:0][15:0]            fragment_slot_packet_id,
    input  logic [FRAG_SLOTS-1:0][12:0]            fragment_slot_next_offset,
    output logic [RX_QUEUES-1:0]                   data_ready,
    output logic [8*DATA_BYTES-1:0]                push_data,
    output logic [DATA_BYTES-1:0]                  push_keep,
    output logic [FRAG_SLOTS-1:0]                  push_data_valid,
    output logic [FRAG_SLOTS-1:0]                  push_data_last,
    output logic [FRAG_SLOTS-1:0]                  slot_claim,
    output logic [15:0]                            packet_id,
    output logic                                   drop_pulse,
    output logic [15:0]                            drop_count
);

    localparam int RQ_W = ptr_width(RX_QUEUES);
    localparam int FS_W = ptr_width(FRAG_SLOTS);
    localparam int FL_W = ptr_width(FLUSH_BEATS + 1);

    state_type               state, state_nxt;
    logic [RQ_W-1:0]         rq, rq_nxt, rq_wrap;
    logic [FS_W-1:0]         fs, fs_nxt;
    logic [FS_W-1:0]         search_cnt, search_cnt_nxt;
    logic [FL_W-1:0]         flush_cnt, flush_cnt_nxt;
    logic [15:0]             lat_id, lat_id_nxt;
    logic                    lat_mf, lat_mf_nxt;
    logic [12:0]             lat_offset, lat_offset_nxt;
    logic                    from_push, from_push_nxt;

    logic [8*DATA_BYTES-1:0] push_data_nxt;
    logic [DATA_BYTES-1:0]   push_keep_nxt;
    logic [FRAG_SLOTS-1:0]   push_valid_nxt, push_last_nxt, slot_claim_nxt;
    logic [15:0]             packet_id_nxt, drop_count_nxt;
    logic                    drop_pulse_nxt;

    logic                    timer_load, timer_run, timer_expired;
    logic                    slot_hit, search_exhausted;

    // DF and reserved flag bits play no part in dispatch.
    logic                    unused_flag_bits;
    assign unused_flag_bits = ^ipv4_flags;

    cycle_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (timer_load),
        .run     (timer_run),
        .expired (timer_expired)
    );

    assign rq_wrap          = (rq == RQ_W'(RX_QUEUES - 1)) ? '0 : rq + RQ_W'(1);
    assign search_exhausted = (search_cnt == FS_W'(FRAG_SLOTS - 1));
    assign slot_hit         = !fragment_slot_empty[fs] &&
                              (fragment_slot_packet_id[fs] == lat_id);

    always_comb begin
        state_nxt      = state;
        rq_nxt         = rq;
        fs_nxt         = fs;
        search_cnt_nxt = search_cnt;
        flush_cnt_nxt  = flush_cnt;
        lat_id_nxt     = lat_id;
        lat_mf_nxt     = lat_mf;
        lat_offset_nxt = lat_offset;
        from_push_nxt  = from_push;
        push_data_nxt  = push_data;
        push_keep_nxt  = push_keep;
        push_valid_nxt = '0;
        push_last_nxt  = '0;
        slot_claim_nxt = '0;
        packet_id_nxt  = packet_id;
        drop_pulse_nxt = 1'b0;
        drop_count_nxt = drop_count;
        data_ready     = '0;
        timer_load     = 1'b0;
        timer_run      = (state == S_PUSH) || (state == S_DRAIN);

        case (state)
            S_IDLE: begin
                lat_id_nxt     = ipv4_identification[rq];
                lat_mf_nxt     = ipv4_flags[rq][IPV4_MF_BIT];
                lat_offset_nxt = ipv4_flags[rq][IPV4_OFFSET_MSB:0];
                if (enable[rq]) begin
                    packet_id_nxt = ipv4_identification[rq];
                    state_nxt     = S_CLASSIFY;
                end else begin
                    rq_nxt = rq_wrap;
                end
            end

            S_CLASSIFY: begin
                fs_nxt         = '0;
                search_cnt_nxt = '0;
                state_nxt      = (lat_offset == '0) ? S_SEARCH_EMPTY : S_SEARCH_MATCH;
            end

            S_SEARCH_EMPTY: begin
                if (fragment_slot_empty[fs]) begin
                    slot_claim_nxt[fs] = 1'b1;
                    timer_load         = 1'b1;
                    state_nxt          = S_PUSH;
                end else if (search_exhausted) begin
                    timer_load = 1'b1;
                    state_nxt  = S_DRAIN;
                end else begin
                    fs_nxt         = fs + FS_W'(1);
                    search_cnt_nxt = search_cnt + FS_W'(1);
                end
            end

            S_SEARCH_MATCH: begin
                if (slot_hit) begin
                    if (fragment_slot_next_offset[fs] == lat_offset) begin
                        flush_cnt_nxt = FL_W'(FLUSH_BEATS);
                        state_nxt     = S_FLUSH;
                    end else begin
                        // Known datagram, but this fragment is out of order.
                        timer_load = 1'b1;
                        state_nxt  = S_DRAIN;
                    end
                end else if (search_exhausted) begin
                    timer_load = 1'b1;
                    state_nxt  = S_DRAIN;
                end else begin
                    fs_nxt         = fs + FS_W'(1);
                    search_cnt_nxt = search_cnt + FS_W'(1);
                end
            end

            S_FLUSH: begin
                // Header beats of continuation fragments are discarded; the
                // zero-count cycle hands over without taking a beat.
                if (flush_cnt != '0) begin
                    data_ready[rq] = data_enable[rq];
                    if (data_enable[rq]) flush_cnt_nxt = flush_cnt - FL_W'(1);
                end else begin
                    timer_load = 1'b1;
                    state_nxt  = S_PUSH;
                end
            end

            S_PUSH: begin
                // A beat arriving on the expiry cycle keeps the datagram open.
                if (data_enable[rq]) begin
                    data_ready[rq]     = 1'b1;
                    push_data_nxt      = data[rq];
                    push_keep_nxt      = data_keep[rq];
                    push_valid_nxt[fs] = 1'b1;
                    timer_load         = 1'b1;
                end else if (timer_expired) begin
                    from_push_nxt = 1'b1;
                    state_nxt     = S_DONE;
                end
            end

            S_DRAIN: begin
                if (data_enable[rq]) begin
                    data_ready[rq] = 1'b1;
                    timer_load     = 1'b1;
                end else if (timer_expired) begin
                    drop_pulse_nxt = 1'b1;
                    if (drop_count != 16'hFFFF) drop_count_nxt = drop_count + 16'd1;
                    from_push_nxt  = 1'b0;
                    state_nxt      = S_DONE;
                end
            end

            S_DONE: begin
                push_last_nxt[fs] = from_push && !lat_mf;
                // Stepping past rq keeps a busy queue from being served twice in a row.
                rq_nxt            = rq_wrap;
                state_nxt         = S_IDLE;
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            rq              <= '0;
            fs              <= '0;
            search_cnt      <= '0;
            flush_cnt       <= '0;
            lat_id          <= '0;
            lat_mf          <= 1'b0;
            lat_offset      <= '0;
            from_push       <= 1'b0;
            push_data       <= '0;
            push_keep       <= '0;
            push_data_valid <= '0;
            push_data_last  <= '0;
            slot_claim      <= '0;
            packet_id       <= '0;
            drop_pulse      <= 1'b0;
            drop_count      <= '0;
        end else begin
            state           <= state_nxt;
            rq              <= rq_nxt;
            fs              <= fs_nxt;
            search_cnt      <= search_cnt_nxt;
            flush_cnt       <= flush_cnt_nxt;
            lat_id          <= lat_id_nxt;
            lat_mf          <= lat_mf_nxt;
            lat_offset      <= lat_offset_nxt;
            from_push       <= from_push_nxt;
            push_data       <= push_data_nxt;
            push_keep       <= push_keep_nxt;
            push_data_valid <= push_valid_nxt;
            push_data_last  <= push_last_nxt;
            slot_claim      <= slot_claim_nxt;
            packet_id       <= packet_id_nxt;
            drop_pulse      <= drop_pulse_nxt;
            drop_count      <= drop_count_nxt;
        end
    end

endmodule

// File: tb/tb_udp_fragment_dispatcher.sv
// Directed bench for udp_fragment_dispatcher (4-byte beats, 4 queues, 4 slots).
module tb_udp_fragment_dispatcher;

    localparam int DB = 4;
    localparam int Q  = 4;
    localparam int F  = 4;
    localparam int FB = 14;
    localparam int TO = 4;

    logic                    clock = 1'b0;
    logic                    reset_n = 1'b0;
    logic [Q-1:0]            enable;
    logic [Q-1:0][8*DB-1:0]  data;
    logic [Q-1:0][DB-1:0]    data_keep;
    logic [Q-1:0]            data_enable;
    logic [Q-1:0][15:0]      ipv4_identification;
    logic [Q-1:0][15:0]      ipv4_flags;
    logic [F-1:0]            fragment_slot_empty;
    logic [F-1:0][15:0]      fragment_slot_packet_id;
    logic [F-1:0][12:0]      fragment_slot_next_offset;
    logic [Q-1:0]            data_ready;
    logic [8*DB-1:0]         push_data;
    logic [DB-1:0]           push_keep;
    logic [F-1:0]            push_data_valid;
    logic [F-1:0]            push_data_last;
    logic [F-1:0]            slot_claim;
    logic [15:0]             packet_id;
    logic                    drop_pulse;
    logic [15:0]             drop_count;

    udp_fragment_dispatcher #(
        .DATA_BYTES(DB), .RX_QUEUES(Q), .FRAG_SLOTS(F),
        .FLUSH_BEATS(FB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .data(data),
        .data_keep(data_keep), .data_enable(data_enable),
        .ipv4_identification(ipv4_identification), .ipv4_flags(ipv4_flags),
        .fragment_slot_empty(fragment_slot_empty),
        .fragment_slot_packet_id(fragment_slot_packet_id),
        .fragment_slot_next_offset(fragment_slot_next_offset),
        .data_ready(data_ready), .push_data(push_data), .push_keep(push_keep),
        .push_data_valid(push_data_valid), .push_data_last(push_data_last),
        .slot_claim(slot_claim), .packet_id(packet_id),
        .drop_pulse(drop_pulse), .drop_count(drop_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            q;
        logic [15:0]   id;
        logic [15:0]   flags;
        int            beats;
        logic [DB-1:0] last_keep;
        logic [F-1:0]  empty;
        logic [63:0]   slot_id;
        logic [51:0]   slot_off;
        logic [F-1:0]  exp_claim;
        int            exp_push;
        logic [F-1:0]  exp_valid;
        logic [F-1:0]  exp_last;
        int            exp_nlast;
        int            exp_drop;
        logic [31:0]   exp_first;
        logic [DB-1:0] exp_keep;
    } vec_t;

    vec_t vecs[7];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_claim, n_push, n_last, n_drop, n_ready;
    int            multi_err = 0;
    int            overlap_err = 0;
    logic [F-1:0]  claim_or, valid_or, last_or;
    logic [DB-1:0] keep_seen;
    logic [31:0]   first_data;
    logic          id_seen;
    logic [15:0]   cur_id;

    function automatic vec_t mk(int q, logic [15:0] id, logic [15:0] flags, int beats,
                                logic [3:0] lkeep, logic [3:0] empty, logic [63:0] sid,
                                logic [51:0] soff, logic [3:0] claim, int npush,
                                logic [3:0] valid, logic [3:0] last, int nlast, int ndrop,
                                logic [31:0] first, logic [3:0] ekeep);
        vec_t v;
        v.q = q; v.id = id; v.flags = flags; v.beats = beats; v.last_keep = lkeep;
        v.empty = empty; v.slot_id = sid; v.slot_off = soff; v.exp_claim = claim;
        v.exp_push = npush; v.exp_valid = valid; v.exp_last = last; v.exp_nlast = nlast;
        v.exp_drop = ndrop; v.exp_first = first; v.exp_keep = ekeep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        if ($countones(data_ready) > 1) multi_err++;
        if ((push_data_valid & push_data_last) != '0) overlap_err++;
        n_ready += $countones(data_ready);
        if (slot_claim != '0) begin n_claim++; claim_or |= slot_claim; end
        if (push_data_valid != '0) begin
            if (n_push == 0) first_data = push_data;
            n_push++;
            valid_or |= push_data_valid;
            keep_seen = push_keep;
        end
        if (push_data_last != '0) begin n_last++; last_or |= push_data_last; end
        if (drop_pulse) n_drop++;
        if (packet_id == cur_id) id_seen = 1'b1;
    endtask

    task automatic clear_stats();
        n_claim = 0; n_push = 0; n_last = 0; n_drop = 0; n_ready = 0;
        claim_or = '0; valid_or = '0; last_or = '0; keep_seen = '0;
        first_data = '0; id_seen = 1'b0;
    endtask

    task automatic drive_beat(input int q, input int idx, input int left, input logic [DB-1:0] lk);
        data[q]        = 32'hA000_0000 | 32'(idx);
        data_keep[q]   = (left == 1) ? lk : '1;
        data_enable[q] = (left > 0);
    endtask

    task automatic run_frame(input int n, input vec_t v);
        int          left, idx, cyc, tail;
        logic        consumed;
        logic [15:0] drops_before;
        string       tag;
        tag = $sformatf("vec%0d", n);
        fragment_slot_empty       = v.empty;
        fragment_slot_packet_id   = v.slot_id;
        fragment_slot_next_offset = v.slot_off;
        ipv4_identification[v.q]  = v.id;
        ipv4_flags[v.q]           = v.flags;
        cur_id = v.id;
        clear_stats();
        drops_before = drop_count;
        left = v.beats; idx = 0; cyc = 0; tail = 0;
        enable[v.q] = 1'b1;
        drive_beat(v.q, idx, left, v.last_keep);
        while (tail < 14 && cyc < 400) begin
            @(negedge clock);
            consumed = data_ready[v.q];
            monitor();
            @(posedge clock); #1;
            cyc++;
            if (consumed && left > 0) begin idx++; left--; end
            if (left == 0) begin
                enable[v.q] = 1'b0;
                data_enable[v.q] = 1'b0;
                tail++;
            end else begin
                drive_beat(v.q, idx, left, v.last_keep);
            end
        end
        check({tag, "_completed"}, 32'(cyc < 400), 32'd1);
        check({tag, "_beats_consumed"}, 32'(n_ready), 32'(v.beats));
        check({tag, "_claim"}, 32'(claim_or), 32'(v.exp_claim));
        check({tag, "_claim_count"}, 32'(n_claim), 32'((v.exp_claim != '0) ? 1 : 0));
        check({tag, "_push_count"}, 32'(n_push), 32'(v.exp_push));
        check({tag, "_push_valid"}, 32'(valid_or), 32'(v.exp_valid));
        check({tag, "_last"}, 32'(last_or), 32'(v.exp_last));
        check({tag, "_last_count"}, 32'(n_last), 32'(v.exp_nlast));
        check({tag, "_drop_pulses"}, 32'(n_drop), 32'(v.exp_drop));
        check({tag, "_drop_count_delta"}, 32'(drop_count - drops_before), 32'(v.exp_drop));
        check({tag, "_packet_id_seen"}, 32'(id_seen), 32'd1);
        if (v.exp_push > 0) begin
            check({tag, "_first_push_data"}, first_data, v.exp_first);
            check({tag, "_final_keep"}, 32'(keep_seen), 32'(v.exp_keep));
        end
    endtask

    localparam logic [63:0] SID_S2   = {16'h0000, 16'h1234, 16'h0000, 16'h0000};
    localparam logic [51:0] OFF_S2_A = {13'h0, 13'h10, 13'h0, 13'h0};
    localparam logic [51:0] OFF_S2_B = {13'h0, 13'h08, 13'h0, 13'h0};
    localparam logic [63:0] SID_FULL = {4{16'h5555}};

    int   k, cyc, nc;
    logic found, claimed;
    int   cq;
    logic [Q-1:0] cons;
    int   order[4];
    int   budget[Q];

    initial begin
        enable = '0; data = '0; data_keep = '0; data_enable = '0;
        ipv4_identification = '0; ipv4_flags = '0;
        fragment_slot_empty = '0; fragment_slot_packet_id = '0; fragment_slot_next_offset = '0;

        vecs[0] = mk(0, 16'h1234, 16'h2000, 6,  4'b0111, 4'b0001, 64'h0, 52'h0,
                     4'b0001, 6, 4'b0001, 4'b0000, 0, 0, 32'hA000_0000, 4'b0111);
        vecs[1] = mk(2, 16'h1234, 16'h0010, 17, 4'b1111, 4'b1011, SID_S2, OFF_S2_A,
                     4'b0000, 3, 4'b0100, 4'b0100, 1, 0, 32'hA000_000E, 4'b1111);
        vecs[2] = mk(2, 16'h1234, 16'h0010, 17, 4'b1111, 4'b1011, SID_S2, OFF_S2_B,
                     4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 32'h0, 4'b0000);
        vecs[3] = mk(1, 16'h7777, 16'h0000, 3,  4'b1111, 4'b0000, SID_FULL, 52'h0,
                     4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 32'h0, 4'b0000);
        vecs[4] = mk(0, 16'h9999, 16'h2008, 2,  4'b1111, 4'b0000, SID_FULL, 52'h0,
                     4'b0000, 0, 4'b0000, 4'b0000, 0, 1, 32'h0, 4'b0000);
        vecs[5] = mk(2, 16'h1234, 16'h0010, 14, 4'b1111, 4'b1011, SID_S2, OFF_S2_A,
                     4'b0000, 0, 4'b0000, 4'b0100, 1, 0, 32'h0, 4'b0000);
        vecs[6] = mk(3, 16'h0042, 16'h0000, 2,  4'b0011, 4'b1110, 64'h0, 52'h0,
                     4'b0010, 2, 4'b0010, 4'b0010, 1, 0, 32'hA000_0000, 4'b0011);

        // Reset state
        repeat (3) @(negedge clock);
        check("reset_data_ready", 32'(data_ready), 32'd0);
        check("reset_push_data", push_data, 32'd0);
        check("reset_push_keep", 32'(push_keep), 32'd0);
        check("reset_push_valid", 32'(push_data_valid), 32'd0);
        check("reset_push_last", 32'(push_data_last), 32'd0);
        check("reset_slot_claim", 32'(slot_claim), 32'd0);
        check("reset_packet_id", 32'(packet_id), 32'd0);
        check("reset_drop", 32'({drop_pulse, drop_count}), 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // All slots full: drain must start after exactly F search cycles.
        fragment_slot_empty = '0;
        fragment_slot_packet_id = SID_FULL;
        ipv4_identification[0] = 16'h7777;
        ipv4_flags[0] = 16'h0000;
        enable[0] = 1'b1;
        drive_beat(0, 0, 1, 4'hF);
        k = 0; found = 1'b0;
        while (!found && k < 20) begin
            @(posedge clock); k++;
            @(negedge clock);
            if (data_ready[0]) found = 1'b1;
        end
        check("search_full_latency", 32'(k), 32'(F + 2));
        @(posedge clock); #1;
        enable[0] = 1'b0; data_enable[0] = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check("search_full_drop_count", 32'(drop_count), 32'd1);

        for (int i = 0; i < 7; i++) run_frame(i, vecs[i]);
        check("table_drop_total", 32'(drop_count), 32'd4);

        // Round robin: queues 1 and 3 enabled continuously.
        fragment_slot_empty = '1;
        ipv4_identification[1] = 16'h0101; ipv4_flags[1] = 16'h0000;
        ipv4_identification[3] = 16'h0303; ipv4_flags[3] = 16'h0000;
        for (int i = 0; i < Q; i++) budget[i] = 0;
        for (int i = 0; i < 4; i++) order[i] = 0;
        cur_id = 16'hFFFF;
        clear_stats();
        enable = 4'b1010; data_enable = '0;
        nc = 0; cyc = 0;
        while (nc < 4 && cyc < 200) begin
            @(negedge clock);
            monitor();
            claimed = (slot_claim != '0);
            cq = int'(packet_id[1:0]);
            if (claimed) begin order[nc] = cq; nc++; end
            cons = data_ready;
            @(posedge clock); #1;
            cyc++;
            for (int i = 0; i < Q; i++) if (cons[i] && budget[i] > 0) budget[i]--;
            if (claimed) budget[cq] = 2;
            for (int i = 0; i < Q; i++) data_enable[i] = (budget[i] > 0);
        end
        enable = '0; data_enable = '0;
        repeat (15) @(posedge clock);
        check("rr_services", 32'(nc), 32'd4);
        check("rr_order0", 32'(order[0]), 32'd1);
        check("rr_order1", 32'(order[1]), 32'd3);
        check("rr_order2", 32'(order[2]), 32'd1);
        check("rr_order3", 32'(order[3]), 32'd3);
        check("ready_onehot", 32'(multi_err), 32'd0);
        check("valid_last_exclusive", 32'(overlap_err), 32'd0);

        // Reset asserted in the middle of S_PUSH.
        fragment_slot_empty = '1;
        ipv4_identification[0] = 16'hBEEF; ipv4_flags[0] = 16'h2000;
        enable[0] = 1'b1; data[0] = 32'hDEAD_0001; data_keep[0] = '1; data_enable[0] = 1'b1;
        k = 0; found = 1'b0;
        while (!found && k < 60) begin
            @(negedge clock); k++;
            if (push_data_valid != '0) found = 1'b1;
        end
        check("midpush_reached", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midpush_reset_ready", 32'(data_ready), 32'd0);
        check("midpush_reset_push", push_data | 32'(push_keep), 32'd0);
        check("midpush_reset_flags", 32'({push_data_valid, push_data_last, slot_claim, drop_pulse}), 32'd0);
        check("midpush_reset_ids", 32'({packet_id, drop_count}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
